// File: rtl/stage0_pkg.sv
// Shared constants for the fetch stage: instruction width and default widths.
package stage0_pkg;

  localparam int INSTR_WIDTH         = 64;
  localparam int DEFAULT_PC_WIDTH    = 10;
  localparam int DEFAULT_COUNT_WIDTH = 6;
  localparam int BUF_DEPTH           = 2;

endpackage

// File: rtl/stage0_fetch_buf.sv
// Two-entry fetch buffer holding instruction, PC and a saturating age per entry.
module fetch_buf
  import stage0_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [INSTR_WIDTH-1:0] push_data,
  input  logic [PC_WIDTH-1:0]    push_pc,
  input  logic                   pop,
  input  logic                   flush,
  output logic [1:0]             count,
  output logic [INSTR_WIDTH-1:0] head_data,
  output logic [PC_WIDTH-1:0]    head_pc,
  output logic [COUNT_WIDTH-1:0] head_age
);

  localparam logic [COUNT_WIDTH-1:0] AGE_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] AGE_ONE = COUNT_WIDTH'(1);

  logic rd_ptr_reg;
  logic wr_ptr_reg;

  logic                   entry_valid [BUF_DEPTH];
  logic [INSTR_WIDTH-1:0] entry_data  [BUF_DEPTH];
  logic [PC_WIDTH-1:0]    entry_pc    [BUF_DEPTH];
  logic [COUNT_WIDTH-1:0] entry_age   [BUF_DEPTH];

  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
    logic                   write_en;
    logic                   read_en;
    logic                   valid_reg;
    logic [INSTR_WIDTH-1:0] data_reg;
    logic [PC_WIDTH-1:0]    pc_reg;
    logic [COUNT_WIDTH-1:0] age_reg;

    assign write_en = push && !flush && (wr_ptr_reg == 1'(gi));
    assign read_en  = pop && !flush && (rd_ptr_reg == 1'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
        pc_reg    <= '0;
        age_reg   <= '0;
      end else begin
        if (flush)         valid_reg <= 1'b0;
        else if (write_en) valid_reg <= 1'b1;
        else if (read_en)  valid_reg <= 1'b0;

        // Age counts cycles spent buffered, starting at 1 in the write cycle's successor.
        if (write_en) begin
          data_reg <= push_data;
          pc_reg   <= push_pc;
          age_reg  <= AGE_ONE;
        end else if (valid_reg && !flush && age_reg != AGE_MAX) begin
          age_reg <= age_reg + AGE_ONE;
        end
      end
    end

    assign entry_valid[gi] = valid_reg;
    assign entry_data[gi]  = data_reg;
    assign entry_pc[gi]    = pc_reg;
    assign entry_age[gi]   = age_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else if (flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
    end
  end

  assign count     = {1'b0, entry_valid[0]} + {1'b0, entry_valid[1]};
  assign head_data = entry_data[rd_ptr_reg];
  assign head_pc   = entry_pc[rd_ptr_reg];
  assign head_age  = entry_age[rd_ptr_reg];

endmodule

// File: rtl/stage0.sv
// Fetch stage: PC sequencing, one-cycle memory read tracking and a 2-entry
// output buffer toward stage1, with branch-mispredict flush and redirect.
module stage0
  import stage0_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_mispredict,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic [PC_WIDTH-1:0]    inst_mem_addr,
  output logic                   inst_mem_rd_en,
  input  logic [INSTR_WIDTH-1:0] inst_mem_data,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [COUNT_WIDTH-1:0] ocount,
  output logic                   vld,
  input  logic                   next_rdy
);

  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] inflight_pc_reg;
  logic                inflight_reg;

  logic [1:0] count;
  logic [2:0] occupancy;
  logic       pop;
  logic       push;
  logic       issue;

  assign vld  = (count != 2'd0) && !branch_mispredict;
  assign pop  = vld && next_rdy;
  assign push = inflight_reg && !branch_mispredict;

  // Slots committed after this cycle's transfer; buffered + in-flight never exceeds two.
  assign occupancy = 3'(count) + 3'(inflight_reg) - 3'(pop);
  assign issue     = !rst && !branch_mispredict && (occupancy < 3'd2);

  assign inst_mem_rd_en = issue;
  assign inst_mem_addr  = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= '0;
      inflight_pc_reg <= '0;
      inflight_reg    <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) inflight_pc_reg <= pc_reg;
      if (branch_mispredict) pc_reg <= branch_target;
      else if (issue)        pc_reg <= pc_reg + PC_WIDTH'(1);
    end
  end

  fetch_buf #(
    .PC_WIDTH   (PC_WIDTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_fetch_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(inst_mem_data),
    .push_pc  (inflight_pc_reg),
    .pop      (pop),
    .flush    (branch_mispredict),
    .count    (count),
    .head_data(instr_out),
    .head_pc  (pc_out),
    .head_age (ocount)
  );

endmodule

// File: tb/tb_stage0.sv
// Bench for stage0: phase table with end-of-phase checkpoints plus a cycle-level
// scoreboard of issued fetches compared against every output each cycle.
module tb_stage0;

  localparam int PCW = 10;
  localparam int CW  = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           branch_mispredict = 1'b0;
  logic [PCW-1:0] branch_target = '0;
  logic           next_rdy = 1'b1;
  logic [PCW-1:0] inst_mem_addr;
  logic           inst_mem_rd_en;
  logic [63:0]    inst_mem_data;
  logic [63:0]    instr_out;
  logic [PCW-1:0] pc_out;
  logic [CW-1:0]  ocount;
  logic           vld;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  stage0 #(.PC_WIDTH(PCW), .COUNT_WIDTH(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .branch_mispredict(branch_mispredict),
    .branch_target    (branch_target),
    .inst_mem_addr    (inst_mem_addr),
    .inst_mem_rd_en   (inst_mem_rd_en),
    .inst_mem_data    (inst_mem_data),
    .instr_out        (instr_out),
    .pc_out           (pc_out),
    .ocount           (ocount),
    .vld              (vld),
    .next_rdy         (next_rdy)
  );

  always #5 clk = ~clk;

  // Memory word[n] = n, valid only in the cycle after a read; otherwise junk.
  always @(posedge clk)
    inst_mem_data <= inst_mem_rd_en ? 64'(inst_mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every issued fetch is queued with the cycle it becomes visible.
  typedef struct {
    logic [PCW-1:0] pc;
    int             ready;
  } fetch_t;

  fetch_t         sb[$];
  logic [PCW-1:0] exp_pc = '0;

  always @(negedge clk) begin : monitor
    bit     ev;
    bit     er;
    bit     pe;
    int     age;
    fetch_t item;
    if (rst) begin
      check("rst_vld", 64'(vld), 64'd0);
      check("rst_rd_en", 64'(inst_mem_rd_en), 64'd0);
      check("rst_addr", 64'(inst_mem_addr), 64'd0);
      check("rst_pc_out", 64'(pc_out), 64'd0);
      check("rst_ocount", 64'(ocount), 64'd0);
      check("rst_instr", instr_out, 64'd0);
      sb.delete();
      exp_pc = '0;
    end else begin
      ev = (sb.size() > 0) && (sb[0].ready <= cyc) && !branch_mispredict;
      pe = ev && next_rdy;
      er = !branch_mispredict && ((sb.size() - int'(pe)) < 2);
      check("sb_vld", 64'(vld), 64'(ev));
      check("sb_rd_en", 64'(inst_mem_rd_en), 64'(er));
      if (er) check("sb_addr", 64'(inst_mem_addr), 64'(exp_pc));
      if (ev) begin
        age = cyc - sb[0].ready + 1;
        if (age > 63) age = 63;
        check("sb_pc_out", 64'(pc_out), 64'(sb[0].pc));
        check("sb_instr", instr_out, 64'(sb[0].pc));
        check("sb_ocount", 64'(ocount), 64'(age));
      end
      if (branch_mispredict) begin
        sb.delete();
        exp_pc = branch_target;
      end else begin
        if (pe) begin
          $display("[TB] cycle %0d transfer pc=%03h instr=%0h age=%0d", cyc, pc_out, instr_out, ocount);
          void'(sb.pop_front());
        end
        if (er) begin
          item.pc    = exp_pc;
          item.ready = cyc + 2;
          sb.push_back(item);
          exp_pc = exp_pc + PCW'(1);
        end
      end
    end
    cyc++;
  end

  typedef struct {
    int             n;
    logic           rdy;
    logic           bm;
    logic [PCW-1:0] tgt;
    logic           e_vld;
    logic           e_rd;
    logic [PCW-1:0] e_addr;
    logic [PCW-1:0] e_pc;
    logic [CW-1:0]  e_age;
  } phase_t;

  phase_t tbl[17];

  initial begin
    // Phase checkpoints, evaluated at the last cycle of each phase.
    tbl[0]  = '{8,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h008, 10'h006, 6'd1};
    tbl[1]  = '{5,  1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h007, 6'd5};
    tbl[2]  = '{1,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h009, 10'h007, 6'd6};
    tbl[3]  = '{4,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h00D, 10'h00B, 6'd1};
    tbl[4]  = '{2,  1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h00C, 6'd2};
    tbl[5]  = '{1,  1'b0, 1'b1, 10'h100, 1'b0, 1'b0, 10'h000, 10'h000, 6'd0};
    tbl[6]  = '{1,  1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h100, 10'h000, 6'd0};
    tbl[7]  = '{2,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h102, 10'h100, 6'd1};
    tbl[8]  = '{1,  1'b1, 1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 10'h000, 6'd0};
    tbl[9]  = '{1,  1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h3FE, 10'h000, 6'd0};
    tbl[10] = '{1,  1'b1, 1'b1, 10'h055, 1'b0, 1'b0, 10'h000, 10'h000, 6'd0};
    tbl[11] = '{1,  1'b1, 1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 10'h000, 6'd0};
    tbl[12] = '{1,  1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h3FE, 10'h000, 6'd0};
    tbl[13] = '{3,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h001, 10'h3FF, 6'd1};
    tbl[14] = '{1,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h002, 10'h000, 6'd1};
    tbl[15] = '{70, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 10'h001, 6'd63};
    tbl[16] = '{3,  1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 10'h005, 10'h003, 6'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_vld", 64'(vld), 64'd0);
    check("init_rd_en", 64'(inst_mem_rd_en), 64'd0);

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_rd_en", 64'(inst_mem_rd_en), 64'd1);
    check("first_addr", 64'(inst_mem_addr), 64'd0);
    check("first_vld", 64'(vld), 64'd0);

    for (int p = 0; p < 17; p++) begin
      for (int k = 0; k < tbl[p].n; k++) begin
        @(posedge clk);
        #1;
        next_rdy          = tbl[p].rdy;
        branch_mispredict = tbl[p].bm;
        branch_target     = tbl[p].tgt;
      end
      @(negedge clk);
      check($sformatf("ph%0d_vld", p), 64'(vld), 64'(tbl[p].e_vld));
      check($sformatf("ph%0d_rd_en", p), 64'(inst_mem_rd_en), 64'(tbl[p].e_rd));
      if (tbl[p].e_rd)
        check($sformatf("ph%0d_addr", p), 64'(inst_mem_addr), 64'(tbl[p].e_addr));
      if (tbl[p].e_vld) begin
        check($sformatf("ph%0d_pc_out", p), 64'(pc_out), 64'(tbl[p].e_pc));
        check($sformatf("ph%0d_instr", p), instr_out, 64'(tbl[p].e_pc));
        check($sformatf("ph%0d_ocount", p), 64'(ocount), 64'(tbl[p].e_age));
      end
    end

    // Asynchronous reset between edges while streaming.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_vld", 64'(vld), 64'd0);
    check("arst_rd_en", 64'(inst_mem_rd_en), 64'd0);
    check("arst_addr", 64'(inst_mem_addr), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rerun_rd_en", 64'(inst_mem_rd_en), 64'd1);
    check("rerun_addr", 64'(inst_mem_addr), 64'd0);
    check("rerun_vld", 64'(vld), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rerun_stream_vld", 64'(vld), 64'd1);
    check("rerun_stream_pc", 64'(pc_out), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
